// File: rtl/pci_arbiter_if.sv
// pci_arbiter_if: bus-side signals shared between the central PCI arbiter and
// the initiators it serves.
//   req      active-low bus requests, one per master
//   frame    active-low PCI FRAME as sampled from the bus
//   irdy     active-low PCI IRDY as sampled from the bus
//   gnt      active-low grants, at most one bit low
//   owner    index of the master currently or last granted
//   bus_busy high while a granted transaction is in flight
// Modport master is the arbiter side; modport slave is the initiator/bus side.
interface pci_arbiter_if #(
  parameter int unsigned N_MASTERS = 4
);
  localparam int unsigned OW = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0] req;
  logic                 frame;
  logic                 irdy;
  logic [N_MASTERS-1:0] gnt;
  logic [OW-1:0]        owner;
  logic                 bus_busy;

  modport master (
    input  req, frame, irdy,
    output gnt, owner, bus_busy
  );

  modport slave (
    output req, frame, irdy,
    input  gnt, owner, bus_busy
  );
endinterface

// File: rtl/pci_arbiter.sv
// pci_arbiter: central round-robin PCI bus arbiter with bus parking and a
// grant timeout for masters that never start a transaction.
//   clk  bus clock, rising edge
//   rst  synchronous active-high reset
//   bus  pci_arbiter_if.master: req/frame/irdy in, gnt/owner/bus_busy out
// All outputs are registered; a grant never moves directly between masters.
module pci_arbiter #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          PARK_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  pci_arbiter_if.master bus
);
  localparam int unsigned OW = $clog2(N_MASTERS);
  localparam int unsigned IW = OW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [OW-1:0]        winner;
  logic [IW-1:0]        idx;
  logic                 found;
  logic                 any_req;
  logic                 bus_idle;

  assign bus_idle = bus.frame & bus.irdy;
  assign any_req  = ~&bus.req;

  // Round-robin pick: search last+1, last+2, ... wrapping, last owner checked last.
  // idx carries one extra bit so last+i never overflows before the wrap.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      idx = {1'b0, last_q} + IW'(i);
      if (idx >= IW'(N_MASTERS)) idx = idx - IW'(N_MASTERS);
      if (!found && !bus.req[idx[OW-1:0]]) begin
        found  = 1'b1;
        winner = idx[OW-1:0];
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '1;
      owner_q <= '0;
      last_q  <= OW'(N_MASTERS - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // Stale or foreign traffic on the bus blocks any new grant.
        if (bus_idle && any_req) state_d = GRANT;
      end
      GRANT: begin
        if (!bus.frame) begin
          state_d = BUSY;
        end else if (!bus.req[owner_q]) begin
          if (cnt_q == CW'(TIMEOUT - 1)) state_d = IDLE;
        end else if (any_req || !PARK_EN) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus_idle) begin
          if ((any_req && (winner == owner_q)) || (!any_req && PARK_EN)) state_d = GRANT;
          else                                                            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the chosen transition.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = '0;
    if (state_q == IDLE && state_d == GRANT) begin
      owner_d = winner;
      last_d  = winner;
    end
    // Idle-cycle counter only runs while the owner keeps requesting an unused bus.
    if (state_q == GRANT && state_d == GRANT && !bus.req[owner_q]) begin
      cnt_d = cnt_q + CW'(1);
    end
    busy_d = (state_d == BUSY);
    gnt_d  = (state_d == IDLE) ? '1 : ~(N_MASTERS'(1) << owner_d);
  end

  assign bus.gnt      = gnt_q;
  assign bus.owner    = owner_q;
  assign bus.bus_busy = busy_q;
endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed scenarios plus randomized traffic for pci_arbiter,
// run on a parking instance and a non-parking instance side by side.
module tb_pci_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] req   = 4'b1111;
  logic       frame = 1'b1;
  logic       irdy  = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pci_arbiter_if #(.N_MASTERS(N)) bus0 ();
  pci_arbiter_if #(.N_MASTERS(N)) bus1 ();

  assign bus0.req   = req;
  assign bus0.frame = frame;
  assign bus0.irdy  = irdy;
  assign bus1.req   = req;
  assign bus1.frame = frame;
  assign bus1.irdy  = irdy;

  pci_arbiter #(.N_MASTERS(N), .TIMEOUT(TO), .PARK_EN(1'b1)) u_park (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  pci_arbiter #(.N_MASTERS(N), .TIMEOUT(TO), .PARK_EN(1'b0)) u_nopark (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Reference model: index 0 parks, index 1 does not. grant = -1 means no grant.
  int m_grant[2] = '{-1, -1};
  int m_owner[2] = '{0, 0};
  int m_ptr[2]   = '{N - 1, N - 1};
  int m_cnt[2]   = '{0, 0};
  bit m_busy[2]  = '{1'b0, 1'b0};

  function automatic int rr_pick(int ptr, logic [3:0] r);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (ptr + k) % N;
      if (!r[2'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt(int g);
    logic [3:0] one;
    one = 4'b0001;
    return (g < 0) ? 4'b1111 : ~(one << g);
  endfunction

  always @(posedge clk) begin
    bit park;
    int pick;
    for (int m = 0; m < 2; m++) begin
      park = (m == 0);
      pick = rr_pick(m_ptr[m], req);
      if (rst) begin
        m_grant[m] = -1; m_owner[m] = 0; m_ptr[m] = N - 1; m_cnt[m] = 0; m_busy[m] = 1'b0;
      end else if (m_grant[m] < 0) begin
        if (frame && irdy && pick >= 0) begin
          m_grant[m] = pick; m_owner[m] = pick; m_ptr[m] = pick; m_cnt[m] = 0;
        end
      end else if (m_busy[m]) begin
        if (frame && irdy) begin
          m_busy[m] = 1'b0;
          m_cnt[m]  = 0;
          if (!((pick == m_grant[m]) || (pick < 0 && park))) m_grant[m] = -1;
        end
      end else if (!frame) begin
        m_busy[m] = 1'b1;
        m_cnt[m]  = 0;
      end else if (!req[2'(m_grant[m])]) begin
        if (m_cnt[m] == TO - 1) begin
          m_grant[m] = -1;
          m_cnt[m]   = 0;
        end else begin
          m_cnt[m] = m_cnt[m] + 1;
        end
      end else begin
        m_cnt[m] = 0;
        if (pick >= 0 || !park) m_grant[m] = -1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b1111; frame = 1'b1; irdy = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({bus0.gnt, bus0.owner, bus0.bus_busy} !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_park: got %b/%0d/%b exp 1111/0/0", bus0.gnt, bus0.owner, bus0.bus_busy);
    end
    n_chk++;
    if ({bus1.gnt, bus1.owner, bus1.bus_busy} !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_nopark: got %b/%0d/%b exp 1111/0/0", bus1.gnt, bus1.owner, bus1.bus_busy);
    end
  endtask

  task automatic test_basic_grant();
    do_reset();
    req = 4'b1110; tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner, bus0.bus_busy} !== {4'b1110, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL first_grant: got %b/%0d/%b exp 1110/0/0", bus0.gnt, bus0.owner, bus0.bus_busy);
    end
    frame = 1'b0; irdy = 1'b0; tick();
    n_chk++;
    if ({bus0.gnt, bus0.bus_busy} !== {4'b1110, 1'b1}) begin
      n_fail++; $display("FAIL go_busy: got %b/%b exp 1110/1", bus0.gnt, bus0.bus_busy);
    end
    frame = 1'b1; irdy = 1'b1; req = 4'b1111; tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner, bus0.bus_busy} !== {4'b1110, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL park_after_busy: got %b/%0d/%b exp 1110/0/0", bus0.gnt, bus0.owner, bus0.bus_busy);
    end
    n_chk++;
    if ({bus1.gnt, bus1.owner, bus1.bus_busy} !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL nopark_after_busy: got %b/%0d/%b exp 1111/0/0", bus1.gnt, bus1.owner, bus1.bus_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] one;
    one = 4'b0001;
    do_reset();
    req = 4'b0000; tick();
    for (int k = 0; k <= 4; k++) begin
      n_chk++;
      if ({bus0.gnt, bus0.owner} !== {~(one << (k % 4)), 2'(k % 4)}) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b/%0d exp %b/%0d", k, bus0.gnt, bus0.owner, ~(one << (k % 4)), k % 4);
      end
      if (k == 4) break;
      frame = 1'b0; irdy = 1'b0;
      for (int t = 0; t < 3; t++) tick();
      frame = 1'b1; irdy = 1'b1; tick();
      n_chk++;
      if (bus0.gnt !== 4'b1111) begin
        n_fail++; $display("FAIL rr_turnaround%0d: got %b exp 1111", k, bus0.gnt);
      end
      tick();
    end
  endtask

  task automatic test_busy_hold();
    do_reset();
    req = 4'b1110; tick();
    frame = 1'b0; irdy = 1'b0; tick();
    req = 4'b0110;
    for (int t = 0; t < 2; t++) begin
      tick();
      n_chk++;
      if ({bus0.gnt, bus0.bus_busy} !== {4'b1110, 1'b1}) begin
        n_fail++; $display("FAIL busy_hold%0d: got %b/%b exp 1110/1", t, bus0.gnt, bus0.bus_busy);
      end
    end
    frame = 1'b1; irdy = 1'b1; tick();
    n_chk++;
    if ({bus0.gnt, bus0.bus_busy} !== {4'b1111, 1'b0}) begin
      n_fail++; $display("FAIL busy_release: got %b/%b exp 1111/0", bus0.gnt, bus0.bus_busy);
    end
    tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner} !== {4'b0111, 2'd3}) begin
      n_fail++; $display("FAIL busy_next_owner: got %b/%0d exp 0111/3", bus0.gnt, bus0.owner);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b1101; tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner} !== {4'b1101, 2'd1}) begin
      n_fail++; $display("FAIL to_grant: got %b/%0d exp 1101/1", bus0.gnt, bus0.owner);
    end
    for (int i = 1; i < TO; i++) begin
      tick();
      n_chk++;
      if (bus0.gnt !== 4'b1101) begin
        n_fail++; $display("FAIL to_hold%0d: got %b exp 1101", i, bus0.gnt);
      end
    end
    tick();
    n_chk++;
    if (bus0.gnt !== 4'b1111) begin
      n_fail++; $display("FAIL to_revoke: got %b exp 1111", bus0.gnt);
    end
    req = 4'b1001; tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner} !== {4'b1011, 2'd2}) begin
      n_fail++; $display("FAIL to_next: got %b/%0d exp 1011/2", bus0.gnt, bus0.owner);
    end
  endtask

  task automatic test_park();
    do_reset();
    req = 4'b1011; tick();
    frame = 1'b0; irdy = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    frame = 1'b1; irdy = 1'b1; req = 4'b1111; tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner, bus0.bus_busy} !== {4'b1011, 2'd2, 1'b0}) begin
      n_fail++; $display("FAIL park_keep: got %b/%0d/%b exp 1011/2/0", bus0.gnt, bus0.owner, bus0.bus_busy);
    end
    n_chk++;
    if ({bus1.gnt, bus1.owner} !== {4'b1111, 2'd2}) begin
      n_fail++; $display("FAIL nopark_drop: got %b/%0d exp 1111/2", bus1.gnt, bus1.owner);
    end
    for (int t = 0; t < 20; t++) begin
      tick();
      n_chk++;
      if (bus0.gnt !== 4'b1011) begin
        n_fail++; $display("FAIL parked%0d: got %b exp 1011", t, bus0.gnt);
      end
    end
    // Counter must start from zero once the parked owner requests again.
    req = 4'b1011;
    for (int i = 1; i < TO; i++) begin
      tick();
      n_chk++;
      if (bus0.gnt !== 4'b1011) begin
        n_fail++; $display("FAIL park_to_hold%0d: got %b exp 1011", i, bus0.gnt);
      end
      if (i == 1) begin
        n_chk++;
        if ({bus1.gnt, bus1.owner} !== {4'b1011, 2'd2}) begin
          n_fail++; $display("FAIL nopark_regrant: got %b/%0d exp 1011/2", bus1.gnt, bus1.owner);
        end
      end
    end
    tick();
    n_chk++;
    if (bus0.gnt !== 4'b1111) begin
      n_fail++; $display("FAIL park_to_revoke: got %b exp 1111", bus0.gnt);
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    req = 4'b1101; tick();
    frame = 1'b0; irdy = 1'b0; tick();
    rst = 1'b1; tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner, bus0.bus_busy} !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_busy: got %b/%0d/%b exp 1111/0/0", bus0.gnt, bus0.owner, bus0.bus_busy);
    end
    rst = 1'b0; req = 4'b0000; frame = 1'b1; irdy = 1'b1; tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner} !== {4'b1110, 2'd0}) begin
      n_fail++; $display("FAIL rst_first_grant: got %b/%0d exp 1110/0", bus0.gnt, bus0.owner);
    end
  endtask

  task automatic test_idle_frame();
    do_reset();
    req = 4'b1110; frame = 1'b0; irdy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_chk++;
      if (bus0.gnt !== 4'b1111) begin
        n_fail++; $display("FAIL stale_frame%0d: got %b exp 1111", t, bus0.gnt);
      end
    end
    frame = 1'b1; irdy = 1'b0; tick();
    n_chk++;
    if (bus0.gnt !== 4'b1111) begin
      n_fail++; $display("FAIL stale_irdy: got %b exp 1111", bus0.gnt);
    end
    irdy = 1'b1; tick();
    n_chk++;
    if ({bus0.gnt, bus0.owner} !== {4'b1110, 2'd0}) begin
      n_fail++; $display("FAIL grant_after_idle: got %b/%0d exp 1110/0", bus0.gnt, bus0.owner);
    end
  endtask

  task automatic test_random();
    int mode;
    mode = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) mode = int'($urandom_range(0, 2));
      rst = ($urandom_range(0, 199) == 0);
      case (mode)
        0: begin
          req   = 4'($urandom);
          frame = ($urandom_range(0, 99) >= 40);
          irdy  = ($urandom_range(0, 99) >= 30);
        end
        1: begin
          // Quiet bus with slowly changing requests exercises timeout and parking.
          frame = 1'b1; irdy = 1'b1;
          if ($urandom_range(0, 19) == 0) req = 4'($urandom);
        end
        default: begin
          if ($urandom_range(0, 3) == 0) req = 4'($urandom);
          frame = ($urandom_range(0, 99) >= 35);
          irdy  = frame ? ($urandom_range(0, 4) != 0) : 1'($urandom);
        end
      endcase
      tick();
      n_chk++;
      if ({bus0.gnt, bus0.owner, bus0.bus_busy} !== {exp_gnt(m_grant[0]), 2'(m_owner[0]), m_busy[0]}) begin
        n_fail++;
        $display("FAIL rand_park cyc %0d: got %b/%0d/%b exp %b/%0d/%b", c, bus0.gnt, bus0.owner, bus0.bus_busy,
                 exp_gnt(m_grant[0]), m_owner[0], m_busy[0]);
      end
      n_chk++;
      if ({bus1.gnt, bus1.owner, bus1.bus_busy} !== {exp_gnt(m_grant[1]), 2'(m_owner[1]), m_busy[1]}) begin
        n_fail++;
        $display("FAIL rand_nopark cyc %0d: got %b/%0d/%b exp %b/%0d/%b", c, bus1.gnt, bus1.owner, bus1.bus_busy,
                 exp_gnt(m_grant[1]), m_owner[1], m_busy[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_busy_hold();
    test_timeout();
    test_park();
    test_reset_busy();
    test_idle_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
